// File: rtl/pipe_cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Holds default geometry and the signed max/min patterns used for saturation.
package pipe_cla_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SEG   = 4;
   localparam int MAX_W     = 64;

   function automatic logic [MAX_W-1:0] smax_of(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction

   function automatic logic [MAX_W-1:0] smin_of(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/pipe_cla_adder_if.sv
// Valid/ready operand and result bus of pipe_cla_adder.
// slave = the adder, master = the producer/consumer driving it.
interface pipe_cla_adder_if
   import pipe_cla_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/cla_segment.sv
// Combinational W-bit carry-lookahead adder segment.
// Every carry is a flat sum-of-products of generate/propagate terms and cin.
module cla_segment #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   logic [W-1:0] p;
   logic [W-1:0] g;
   logic [W:0]   c;
   logic         term;
   logic         prod;

   assign p = a ^ b;
   assign g = a & b;

   always_comb begin
      c    = '0;
      term = 1'b0;
      prod = 1'b0;
      c[0] = cin;
      for (int i = 0; i < W; i++) begin
         term = g[i];
         prod = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            term = term | (prod & g[j]);
            prod = prod & p[j];
         end
         c[i+1] = term | (prod & cin);
      end
   end

   assign s    = p ^ c[W-1:0];
   assign cout = c[W];
endmodule

// File: rtl/pipe_cla_adder.sv
// Segmented pipelined CLA adder/subtractor, NSEG = WIDTH/SEG stages, latency NSEG.
// Define PIPE_CLA_SAT_EN to clamp the sum to the signed range on overflow.
module pipe_cla_adder
   import pipe_cla_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG   = DEF_SEG
) (
   input logic              clk,
   input logic              rst_n,
   pipe_cla_adder_if.slave  bus
);
   localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
   localparam int NSEG     = WIDTH / SEG_SAFE;

   if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_cfg_check
      $error("pipe_cla_adder: SEG must be >= 1 and divide WIDTH");
   end

`ifdef PIPE_CLA_SAT_EN
   localparam logic signed [WIDTH-1:0] SMAX = WIDTH'(smax_of(WIDTH));
   localparam logic signed [WIDTH-1:0] SMIN = WIDTH'(smin_of(WIDTH));

   function automatic logic signed [WIDTH-1:0] saturate(
      input logic signed [WIDTH-1:0] raw,
      input logic                    ovf,
      input logic                    neg
   );
      if (!ovf) return raw;
      return neg ? SMIN : SMAX;
   endfunction
`endif

   logic             adv;
   logic             out_vld;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Whole pipeline stalls together when a result is waiting and not taken.
   assign adv          = !out_vld | bus.out_ready;
   assign bus.in_ready = adv;
   assign b_eff        = bus.b ^ {WIDTH{bus.sub}};
   assign cin_eff      = bus.sub | bus.cin;

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      localparam int RW = WIDTH - k * SEG_SAFE;
      localparam int LW = (k + 1) * SEG_SAFE;

      logic [RW-1:0]       a_i;
      logic [RW-1:0]       b_i;
      logic                c_i;
      logic                v_i;
      logic [SEG_SAFE-1:0] seg_s;
      logic                seg_c;
      logic [LW-1:0]       s_n;
      logic                vld_p;

      if (k == 0) begin : g_first
         assign a_i = bus.a;
         assign b_i = b_eff;
         assign c_i = cin_eff;
         assign v_i = bus.in_valid;
         assign s_n = seg_s;
      end else begin : g_next
         assign a_i = g_stage[k-1].g_pipe.a_p;
         assign b_i = g_stage[k-1].g_pipe.b_p;
         assign c_i = g_stage[k-1].g_pipe.c_p;
         assign v_i = g_stage[k-1].vld_p;
         assign s_n = {seg_s, g_stage[k-1].g_pipe.s_p};
      end

      cla_segment #(.W(SEG_SAFE)) u_seg (
         .a    (a_i[SEG_SAFE-1:0]),
         .b    (b_i[SEG_SAFE-1:0]),
         .cin  (c_i),
         .s    (seg_s),
         .cout (seg_c)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)   vld_p <= 1'b0;
         else if (adv) vld_p <= v_i;
      end

      if (k < NSEG - 1) begin : g_pipe
         // Stage k -> k+1: carry the not-yet-added upper operand bits forward.
         logic [RW-SEG_SAFE-1:0] a_p;
         logic [RW-SEG_SAFE-1:0] b_p;
         logic [LW-1:0]          s_p;
         logic                   c_p;

         always_ff @(posedge clk) begin
            if (adv) begin
               a_p <= a_i[RW-1:SEG_SAFE];
               b_p <= b_i[RW-1:SEG_SAFE];
               s_p <= s_n;
               c_p <= seg_c;
            end
         end
      end else begin : g_out
         // Final stage: the top segment holds the operand MSBs for overflow.
         logic                    ovf_raw;
         logic signed [WIDTH-1:0] res;
         logic [WIDTH-1:0]        sum_p;
         logic                    cout_p;
         logic                    ovf_p;

         assign ovf_raw = (a_i[SEG_SAFE-1] == b_i[SEG_SAFE-1]) &
                          (seg_s[SEG_SAFE-1] != a_i[SEG_SAFE-1]);
`ifdef PIPE_CLA_SAT_EN
         assign res = saturate(s_n, ovf_raw, a_i[SEG_SAFE-1]);
`else
         assign res = s_n;
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sum_p  <= '0;
               cout_p <= 1'b0;
               ovf_p  <= 1'b0;
            end else if (adv && v_i) begin
               sum_p  <= res;
               cout_p <= seg_c;
               ovf_p  <= ovf_raw;
            end
         end
      end
   end

   assign out_vld       = g_stage[NSEG-1].vld_p;
   assign bus.out_valid = out_vld;
   assign bus.sum       = g_stage[NSEG-1].g_out.sum_p;
   assign bus.cout      = g_stage[NSEG-1].g_out.cout_p;
   assign bus.ovf       = g_stage[NSEG-1].g_out.ovf_p;
endmodule

// File: tb/tb_pipe_cla_adder.sv
// Directed bench for pipe_cla_adder at WIDTH=16, SEG=4 (latency 4).
// Expected sums follow PIPE_CLA_SAT_EN when the bench is built with it.
module tb_pipe_cla_adder;
   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   pipe_cla_adder_if #(.WIDTH(16)) bus ();

   pipe_cla_adder #(.WIDTH(16), .SEG(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] bb_a   [8] = '{16'h0001, 16'h000F, 16'h00F0, 16'h0FFF,
                               16'h1234, 16'hFFFF, 16'hABCD, 16'h8000};
   logic [15:0] bb_b   [8] = '{16'h0001, 16'h0001, 16'h0010, 16'h0001,
                               16'h4321, 16'h0001, 16'h1111, 16'h7FFF};
   logic [15:0] bb_sum [8] = '{16'h0002, 16'h0010, 16'h0100, 16'h1000,
                               16'h5555, 16'h0000, 16'hBCDE, 16'hFFFF};

   task automatic run_single(input logic [15:0] ia, input logic [15:0] ib,
                             input logic ic, input logic is,
                             output logic [15:0] osum, output logic oc,
                             output logic oo, output int lat);
      @(negedge clk);
      bus.a = ia; bus.b = ib; bus.cin = ic; bus.sub = is;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      osum = bus.sum; oc = bus.cout; oo = bus.ovf;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      bus.sub = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", bus.sum); else passed++;
      total++; if (bus.cout !== 1'b0) $display("FAIL reset_cout got %b want 0", bus.cout); else passed++;
      total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.ovf); else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
   endtask

   task automatic test_add();
      logic [15:0] s; logic c, o; int lat;
      run_single(16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
      total++; if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat); else passed++;
      total++; if (s !== 16'h0100) $display("FAIL add_sum got %h want 0100", s); else passed++;
      total++; if (c !== 1'b0) $display("FAIL add_cout got %b want 0", c); else passed++;
      total++; if (o !== 1'b0) $display("FAIL add_ovf got %b want 0", o); else passed++;
      run_single(16'hFFFF, 16'h0000, 1'b1, 1'b0, s, c, o, lat);
      total++; if (s !== 16'h0000) $display("FAIL add_cin_sum got %h want 0000", s); else passed++;
      total++; if (c !== 1'b1) $display("FAIL add_cin_cout got %b want 1", c); else passed++;
      total++; if (o !== 1'b0) $display("FAIL add_cin_ovf got %b want 0", o); else passed++;
   endtask

   task automatic test_overflow();
      logic [15:0] s; logic c, o; int lat;
      logic [15:0] exp_pos, exp_neg;
`ifdef PIPE_CLA_SAT_EN
      exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
      exp_pos = 16'h8000; exp_neg = 16'h0000;
`endif
      run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
      total++; if (s !== exp_pos) $display("FAIL ovf_pos_sum got %h want %h", s, exp_pos); else passed++;
      total++; if (o !== 1'b1) $display("FAIL ovf_pos_flag got %b want 1", o); else passed++;
      total++; if (c !== 1'b0) $display("FAIL ovf_pos_cout got %b want 0", c); else passed++;
      run_single(16'h8000, 16'h8000, 1'b0, 1'b0, s, c, o, lat);
      total++; if (s !== exp_neg) $display("FAIL ovf_neg_sum got %h want %h", s, exp_neg); else passed++;
      total++; if (o !== 1'b1) $display("FAIL ovf_neg_flag got %b want 1", o); else passed++;
      total++; if (c !== 1'b1) $display("FAIL ovf_neg_cout got %b want 1", c); else passed++;
   endtask

   task automatic test_sub();
      logic [15:0] s; logic c, o; int lat;
      logic [15:0] exp_min;
`ifdef PIPE_CLA_SAT_EN
      exp_min = 16'h8000;
`else
      exp_min = 16'h7FFF;
`endif
      // cin is driven high to show it has no effect while subtracting.
      run_single(16'h0000, 16'h0001, 1'b1, 1'b1, s, c, o, lat);
      total++; if (s !== 16'hFFFF) $display("FAIL sub_sum got %h want FFFF", s); else passed++;
      total++; if (c !== 1'b0) $display("FAIL sub_cout got %b want 0", c); else passed++;
      total++; if (o !== 1'b0) $display("FAIL sub_ovf got %b want 0", o); else passed++;
      run_single(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, o, lat);
      total++; if (o !== 1'b1) $display("FAIL sub_ovf_flag got %b want 1", o); else passed++;
      total++; if (s !== exp_min) $display("FAIL sub_ovf_sum got %h want %h", s, exp_min); else passed++;
      total++; if (c !== 1'b1) $display("FAIL sub_ovf_cout got %b want 1", c); else passed++;
   endtask

   task automatic test_back_to_back();
      int nres = 0;
      bus.out_ready = 1'b1; bus.cin = 1'b0; bus.sub = 1'b0;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (nres < 8) begin
               total++; if (n !== 4 + nres) $display("FAIL b2b_timing[%0d] got cycle %0d want %0d", nres, n, 4 + nres); else passed++;
               total++; if (bus.sum !== bb_sum[nres]) $display("FAIL b2b_sum[%0d] got %h want %h", nres, bus.sum, bb_sum[nres]); else passed++;
            end
            nres++;
         end
         if (n < 8) begin
            bus.a = bb_a[n]; bus.b = bb_b[n]; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      total++; if (nres !== 8) $display("FAIL b2b_count got %0d want 8", nres); else passed++;
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int ridx = 0;
      int extra = 0;
      bus.cin = 1'b0; bus.sub = 1'b0;
      for (int n = 0; n < 40 && ridx < 8; n++) begin
         @(negedge clk);
         bus.out_ready = !(n >= 6 && n < 12);
         #1;
         if (bus.out_valid) begin
            if (!bus.out_ready) begin
               total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b want 0", n, bus.in_ready); else passed++;
               total++; if (ridx < 8 && bus.sum !== bb_sum[ridx]) $display("FAIL bp_hold_sum cycle %0d got %h want %h", n, bus.sum, bb_sum[ridx]); else passed++;
            end else begin
               total++; if (ridx < 8 && bus.sum !== bb_sum[ridx]) $display("FAIL bp_sum[%0d] got %h want %h", ridx, bus.sum, bb_sum[ridx]); else passed++;
               ridx++;
            end
         end
         bus.in_valid = (idx < 8);
         if (idx < 8) begin
            bus.a = bb_a[idx]; bus.b = bb_b[idx];
         end
         #1;
         if (bus.in_valid && bus.in_ready) idx++;
      end
      total++; if (ridx !== 8) $display("FAIL bp_count got %0d want 8", ridx); else passed++;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (bus.out_valid) extra++;
      end
      total++; if (extra !== 0) $display("FAIL bp_duplicates got %0d want 0", extra); else passed++;
   endtask

   task automatic test_reset_flush();
      logic [15:0] s; logic c, o; int lat;
      int seen = 0;
      bus.out_ready = 1'b1; bus.cin = 1'b0; bus.sub = 1'b0;
      @(negedge clk); bus.a = 16'h1111; bus.b = 16'h1111; bus.in_valid = 1'b1;
      @(negedge clk); bus.a = 16'h2222; bus.b = 16'h2222;
      @(negedge clk); bus.a = 16'h3333; bus.b = 16'h3333;
      @(negedge clk); bus.in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.sum !== 16'h0000) $display("FAIL flush_sum got %h want 0000", bus.sum); else passed++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      total++; if (seen !== 0) $display("FAIL flush_ghost_results got %0d want 0", seen); else passed++;
      run_single(16'h0002, 16'h0003, 1'b0, 1'b0, s, c, o, lat);
      total++; if (lat !== 4) $display("FAIL flush_first_latency got %0d want 4", lat); else passed++;
      total++; if (s !== 16'h0005) $display("FAIL flush_first_sum got %h want 0005", s); else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_overflow();
      test_sub();
      test_back_to_back();
      test_backpressure();
      test_reset_flush();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL have parameter SEG, default 4, bits per pipeline segment; NSEG = WIDTH/SEG.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands present.
REQ-006 SHALL have port in_ready, output, 1, operands accepted this cycle.
REQ-007 SHALL have port a, input, WIDTH, operand A.
REQ-008 SHALL have port b, input, WIDTH, operand B.
REQ-009 SHALL have port cin, input, 1, carry-in (add mode only).
REQ-010 SHALL have port sub, input, 1, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer takes result.
REQ-013 SHALL have port sum, output, WIDTH, result.
REQ-014 SHALL have port cout, output, 1, carry out of MSB.
REQ-015 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-016 SHALL compute a+b+cin when sub=0, and a+~b+1 when sub=1 with cin ignored.
REQ-017 SHALL split the add into NSEG stages; stage k adds bits [k*SEG +: SEG] using a SEG-bit carry-lookahead segment fed by the registered carry of stage k-1.
REQ-018 SHALL skew upper operand segments through delay registers and de-skew lower sum segments, so that all bits of one operation emerge together.
REQ-019 SHALL have a latency of exactly NSEG cycles from an accepted transfer (in_valid & in_ready) to out_valid, with no backpressure.
REQ-020 SHALL advance the pipeline as a whole: adv = !out_valid | out_ready; in_ready = adv.
REQ-021 SHALL sustain throughput of one operation per cycle while out_ready=1.
REQ-022 SHALL hold out_valid, sum, cout and ovf stable while out_valid=1 and out_ready=0; no operation is lost or duplicated.
REQ-023 SHALL advance bubbles when in_valid=0 and adv=1; a bubble SHALL never raise out_valid.
REQ-024 SHALL set ovf = (a[MSB]==b_eff[MSB]) & (raw_sum[MSB]!=a[MSB]), where b_eff is b or ~b.
REQ-025 SHALL, when WIDTH==SEG, operate with latency 1 as a single registered stage.
REQ-026 SHALL fail elaboration if WIDTH%SEG!=0 or SEG<1.

Reset
REQ-027 SHALL clear all stage-valid flags and drive out_valid=0, sum=0, cout=0, ovf=0 while rst_n=0.
REQ-028 SHALL discard every in-flight operation on reset assertion mid-operation; the first accept after release SHALL produce the first result.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset release.

Configuration
REQ-030 SHALL, with PIPE_CLA_SAT_EN defined, clamp sum to 0x7FFF..F (positive overflow) or 0x800..0 (negative overflow) whenever ovf=1; ovf and cout still report the unclamped result.
REQ-031 SHALL, without PIPE_CLA_SAT_EN, output the wrapped modulo-2^WIDTH sum and add no saturation logic.

Structure
REQ-032 SHALL take the default WIDTH/SEG constants and the signed max/min helper constants from shared package pipe_cla_pkg.
REQ-033 SHALL instantiate NSEG copies of combinational sub-module cla_segment (SEG-bit P/G lookahead: a, b, cin -> s, cout).

Verification (WIDTH=16, SEG=4)
REQ-034 Test: a=0x00FF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0100, cout=0, ovf=0.
REQ-035 Test: a=0x7FFF, b=0x0001, sub=0 -> ovf=1; sum=0x8000 without the macro, sum=0x7FFF with PIPE_CLA_SAT_EN.
REQ-036 Test: a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> ovf=1.
REQ-037 Test: 8 back-to-back ops, out_ready=1 -> 8 results on consecutive cycles, starting 4 cycles after the first accept, in order.
REQ-038 Test: out_ready=0 for 6 cycles mid-stream -> in_ready=0, outputs stable, no loss or duplication after release.
REQ-039 Test: rst_n pulsed low with 3 ops in flight -> out_valid=0 and none of the 3 results ever appears.
